cacheline_burst_responder: RTL and testbench

Responder end of the line-request interface that the cache arbiter initiates on its shared downstream port. It accepts one full-line read or write at a time using the held-request / single-cycle-response handshake, and converts it into a fixed-length burst on the physical-memory port. It also assembles returned beats into a line, or slices the write line into beats. It sits between the arbiter's downstream port and physical memory.

---
 rtl/cacheline_burst_responder.sv | 167 ++++++++++++++++
 tb/tb_cacheline_burst_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_responder.sv
// cacheline_burst_responder
// Accepts one full-line read or write from the cache arbiter's downstream port
// (held request / single-cycle response) and turns it into a fixed-length
// burst on the physical-memory port. Read beats are assembled into a line
// buffer; the write line is latched and presented one beat at a time.
// Beat k occupies line bits [k*s_burst +: s_burst], so beat 0 is the LSBs.

module cacheline_burst_responder #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic                clk,
  input  logic                rst,

  // line-request side (arbiter downstream port)
  input  logic                line_read,
  input  logic                line_write,
  input  logic [31:0]         line_address,
  input  logic [s_line-1:0]   line_wdata,
  output logic                line_resp,
  output logic [s_line-1:0]   line_rdata,

  // physical-memory burst side
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [31:0]         pmem_address,
  output logic [s_burst-1:0]  pmem_wdata,
  input  logic                pmem_resp,
  input  logic [s_burst-1:0]  pmem_rdata
);

  localparam int BEATS = s_line / s_burst;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [CNT_W-1:0]   count_reg;
  logic [31:0]        addr_reg;
  logic [s_line-1:0]  wline_reg;
  logic [s_burst-1:0] rbeat_reg [BEATS];
  logic [s_burst-1:0] wbeat     [BEATS];

  // Handshake decodes. A simultaneous read and write is illegal; read wins.
  logic accept_rd;
  logic accept_wr;
  logic in_burst;
  logic beat_ack;
  logic last_ack;

  assign accept_rd = (state_reg == IDLE) && line_read;
  assign accept_wr = (state_reg == IDLE) && line_write && !line_read;
  assign in_burst  = (state_reg == READ) || (state_reg == WRITE);
  // pmem_resp outside a burst (IDLE or DONE) is ignored.
  assign beat_ack  = in_burst && pmem_resp;
  assign last_ack  = beat_ack && (count_reg == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: request sampled only in IDLE, burst ends on the last beat ack.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept_rd) begin
          state_next = READ;
        end else if (accept_wr) begin
          state_next = WRITE;
        end
      end
      READ: begin
        if (last_ack) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        if (last_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state: strobes held for the whole burst, one-cycle resp.
  always_comb begin
    line_resp  = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    unique case (state_reg)
      READ:    pmem_read  = 1'b1;
      WRITE:   pmem_write = 1'b1;
      DONE:    line_resp  = 1'b1;
      default: begin
        line_resp  = 1'b0;
      end
    endcase
  end

  // Beat counter: cleared on acceptance, advanced on every acknowledged beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (accept_rd || accept_wr) begin
      count_reg <= '0;
    end else if (beat_ack) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Address and write line latched at acceptance; later changes on line_* are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wline_reg <= '0;
    end else if (accept_rd) begin
      addr_reg  <= {line_address[31:s_offset], {s_offset{1'b0}}};
    end else if (accept_wr) begin
      addr_reg  <= {line_address[31:s_offset], {s_offset{1'b0}}};
      wline_reg <= line_wdata;
    end
  end

  // Per-beat slicing of the write line and per-beat capture of read data.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign wbeat[gi] = wline_reg[gi*s_burst +: s_burst];

      // Capture a read beat into its slot when it is acknowledged.
      always_ff @(posedge clk) begin
        if (rst) begin
          rbeat_reg[gi] <= '0;
        end else if ((state_reg == READ) && pmem_resp && (count_reg == CNT_W'(gi))) begin
          rbeat_reg[gi] <= pmem_rdata;
        end
      end

      assign line_rdata[gi*s_burst +: s_burst] = rbeat_reg[gi];
    end
  endgenerate

  // The current write beat only moves after its ack, so it is stable until taken.
  assign pmem_wdata   = wbeat[count_reg];
  assign pmem_address = addr_reg;

endmodule

// File: tb/tb_cacheline_burst_responder.sv
module tb_cacheline_burst_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic         line_resp;
  logic [255:0] line_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic         pmem_resp;
  logic [63:0]  pmem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  cacheline_burst_responder dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_resp    (line_resp),
    .line_rdata   (line_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rbeats;   // beat k supplied by memory = rbeats[k*64 +: 64]
    bit   [15:0]  gaps;     // stall cycles before beat k = gaps[k*4 +: 4]
    bit           hold;     // keep request asserted through line_resp
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one line transaction starting in an IDLE cycle and checks every
  // cycle of it against the transaction-level expectation.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rbeats,
                         input bit [15:0] gaps, input bit hold, input bit perturb,
                         input logic [31:0] exp_addr, input logic [255:0] exp_line);
    bit is_rd;
    bit is_wr;
    int g;
    is_rd = rd;
    is_wr = !rd && wr;
    @(negedge clk);
    check("idle_resp", line_resp, 0);
    check("idle_pmem_read", pmem_read, 0);
    check("idle_pmem_write", pmem_write, 0);
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = wline;
    pmem_resp    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = int'(gaps[k*4 +: 4]);
      for (int j = 0; j <= g; j++) begin
        @(negedge clk);
        check("burst_pmem_read", pmem_read, is_rd);
        check("burst_pmem_write", pmem_write, is_wr);
        check("burst_address", pmem_address, exp_addr);
        check("burst_resp", line_resp, 0);
        if (is_wr) check("burst_wdata", pmem_wdata, wline[k*64 +: 64]);
        if (perturb) begin
          line_read    = 1'($urandom);
          line_write   = 1'($urandom);
          line_address = $urandom;
          line_wdata   = rand256();
        end
        if (j == g) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rbeats[k*64 +: 64];
        end else begin
          pmem_resp  = 1'b0;
          pmem_rdata = 64'($urandom);
        end
      end
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    check("done_resp", line_resp, 1);
    check("done_pmem_read", pmem_read, 0);
    check("done_pmem_write", pmem_write, 0);
    if (is_rd) check("done_rdata", line_rdata, exp_line);
    if (hold) begin
      line_read  = rd;
      line_write = wr;
    end else begin
      line_read  = 1'b0;
      line_write = 1'b0;
    end
    n_txn++;
    $display("txn %0d: %s addr=%h burst=%h gaps=%h", n_txn, is_rd ? "read " : "write",
             addr, exp_addr, gaps);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] last_line;
    logic [255:0] rb;
    logic [255:0] wl;
    logic [31:0]  a;
    bit           rd;
    bit           wr;
    bit   [15:0]  gp;

    // Directed vectors.
    vecs[0] = '{rd: 1, wr: 0, addr: 32'h0000_1234, wline: '0,
                rbeats: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                gaps: 16'h0000, hold: 0, exp_addr: 32'h0000_1220,
                exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{rd: 0, wr: 1, addr: 32'h0000_4008,
                wline: {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
                rbeats: '0, gaps: 16'h2220, hold: 0, exp_addr: 32'h0000_4000,
                exp_line: '0};
    vecs[2] = '{rd: 1, wr: 1, addr: 32'h0000_0FFF, wline: {8{32'hDEAD_BEEF}},
                rbeats: {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F,
                         64'hFEDC_BA98_7654_3210, 64'h5A5A_5A5A_5A5A_5A5A},
                gaps: 16'h0101, hold: 0, exp_addr: 32'h0000_0FE0,
                exp_line: {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F,
                           64'hFEDC_BA98_7654_3210, 64'h5A5A_5A5A_5A5A_5A5A}};
    vecs[3] = '{rd: 1, wr: 0, addr: 32'h0000_0100, wline: '0,
                rbeats: {64'hA1, 64'hA2, 64'hA3, 64'hA4}, gaps: 16'h0000, hold: 1,
                exp_addr: 32'h0000_0100, exp_line: {64'hA1, 64'hA2, 64'hA3, 64'hA4}};
    vecs[4] = '{rd: 1, wr: 0, addr: 32'h0000_0200, wline: '0,
                rbeats: {64'hB1, 64'hB2, 64'hB3, 64'hB4}, gaps: 16'h0100, hold: 0,
                exp_addr: 32'h0000_0200, exp_line: {64'hB1, 64'hB2, 64'hB3, 64'hB4}};

    rst          = 1'b1;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    pmem_resp    = 1'b0;
    pmem_rdata   = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", line_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_address", pmem_address, 0);
    check("rst_wdata", pmem_wdata, 0);
    check("rst_rdata", line_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wline, vecs[i].rbeats,
              vecs[i].gaps, vecs[i].hold, 1'b0, vecs[i].exp_addr, vecs[i].exp_line);
    end

    // Reset in the middle of a read burst, after the second beat.
    @(negedge clk);
    line_read    = 1'b1;
    line_address = 32'h0000_3000;
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = 64'hCAFE_0000_0000_0001;
    @(negedge clk);
    pmem_rdata = 64'hCAFE_0000_0000_0002;
    @(negedge clk);
    pmem_resp = 1'b0;
    line_read = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("midrst_pmem_read", pmem_read, 0);
    check("midrst_resp", line_resp, 0);
    check("midrst_rdata", line_rdata, 0);
    check("midrst_address", pmem_address, 0);
    rst = 1'b0;
    last_line = {64'hE4, 64'hE3, 64'hE2, 64'hE1};
    run_txn(1'b1, 1'b0, 32'h0000_3047, '0, last_line, 16'h0000, 1'b0, 1'b0,
            32'h0000_3040, last_line);

    // Spurious pmem_resp while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idleresp_resp", line_resp, 0);
      check("idleresp_pmem_read", pmem_read, 0);
      check("idleresp_rdata", line_rdata, last_line);
      pmem_resp  = 1'b1;
      pmem_rdata = 64'($urandom);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    check("idleresp_resp_end", line_resp, 0);
    check("idleresp_rdata_end", line_rdata, last_line);

    // Randomized traffic with request perturbation mid-burst, against the
    // line-level model: aligned address, beat k <-> line bits [k*64 +: 64].
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      a  = $urandom;
      wl = rand256();
      rb = rand256();
      for (int k = 0; k < 4; k++) gp[k*4 +: 4] = 4'($urandom_range(0, 3));
      run_txn(rd, wr, a, wl, rb, gp, 1'($urandom), 1'b1, a & ~32'h1F, rb);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
